// File: rtl/duty_ramp_if.sv
// Duty ramp control/status bundle: run/fault/target requests in, duty word
// and status flags out.
// The bus is a set of level signals sampled every clock; there is no
// valid/ready pair, every signal is meaningful on every cycle.
interface duty_ramp_if #(
    parameter int WIDTH = 10
);
    logic             en;
    logic             fault;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] d;
    logic             at_target;
    logic             fault_latched;
    logic             busy;
    logic [2:0]       state_dbg;

    modport master (
        output en, fault, target,
        input  d, at_target, fault_latched, busy, state_dbg
    );

    modport slave (
        input  en, fault, target,
        output d, at_target, fault_latched, busy, state_dbg
    );
endinterface

// File: rtl/duty_ramp.sv
// Slew-limited duty setpoint for the half-bridge PWM. Moves the duty word
// toward the clamped target by at most STEP per ramp tick, soft-stops to
// zero when the run request drops, and drops to zero at once on fault.
module duty_ramp #(
    parameter int WIDTH    = 10,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 50000,
    parameter int DUTY_MAX = 1000
) (
    input logic        clk,
    input logic        rst,
    duty_ramp_if.slave bus
);
    localparam int               PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(DUTY_MAX);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [PW-1:0]    LAST   = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        HOLD  = 3'd2,
        STOP  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] d_q, d_n;
    logic [PW-1:0]    pre, pre_n, pre_inc;
    logic [WIDTH-1:0] tgt;
    logic             tick;
    logic             at_target_q, fault_latched_q, busy_q;

    // One step of at most STEP toward goal; the difference is taken in
    // WIDTH+1 bits so it never wraps, and a close goal is landed on exactly.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] goal);
        logic [WIDTH:0] c;
        logic [WIDTH:0] g;
        logic [WIDTH:0] sum;
        c   = {1'b0, cur};
        g   = {1'b0, goal};
        sum = c + STEP_W;
        if (c < g) begin
            return ((g - c) <= STEP_W) ? goal : sum[WIDTH-1:0];
        end else begin
            return ((c - g) <= STEP_W) ? goal : cur - STEP_W[WIDTH-1:0];
        end
    endfunction

    // Clamped target and tick decode from the prescaler.
    always_comb begin
        tgt     = (bus.target > MAX_W) ? MAX_W : bus.target;
        tick    = (pre == LAST);
        pre_inc = tick ? '0 : pre + PW'(1);
    end

    // Next-state, next-duty and prescaler logic; fault overrides everything.
    always_comb begin
        state_n = state;
        d_n     = d_q;
        pre_n   = '0;
        case (state)
            IDLE: begin
                d_n = '0;
                if (bus.en) state_n = (tgt != '0) ? RAMP : HOLD;
            end
            RAMP: begin
                if (!bus.en) begin
                    // Soft stop keeps the running tick cadence.
                    state_n = STOP;
                    pre_n   = pre_inc;
                end else if (d_q == tgt) begin
                    state_n = HOLD;
                end else if (tick) begin
                    d_n = step_toward(d_q, tgt);
                    if (d_n == tgt) state_n = HOLD;
                end else begin
                    pre_n = pre_inc;
                end
            end
            HOLD: begin
                if (!bus.en)          state_n = (d_q == '0) ? IDLE : STOP;
                else if (tgt != d_q)  state_n = RAMP;
            end
            STOP: begin
                if (bus.en) begin
                    state_n = RAMP;
                end else if (d_q == '0) begin
                    state_n = IDLE;
                end else if (tick) begin
                    d_n = step_toward(d_q, '0);
                    if (d_n == '0) state_n = IDLE;
                end else begin
                    pre_n = pre_inc;
                end
            end
            FAULT: begin
                d_n = '0;
                // Re-arm only once the run request has been released.
                if (!bus.fault && !bus.en) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                d_n     = '0;
            end
        endcase
        if (bus.fault) begin
            state_n = FAULT;
            d_n     = '0;
            pre_n   = '0;
        end
    end

    // State, duty and status registers; flags reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            d_q             <= '0;
            pre             <= '0;
            at_target_q     <= 1'b0;
            fault_latched_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state           <= state_n;
            d_q             <= d_n;
            pre             <= pre_n;
            at_target_q     <= (state_n == HOLD);
            fault_latched_q <= (state_n == FAULT);
            busy_q          <= (state_n == RAMP) || (state_n == STOP);
        end
    end

    assign bus.d             = d_q;
    assign bus.at_target     = at_target_q;
    assign bus.fault_latched = fault_latched_q;
    assign bus.busy          = busy_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: two instances (STEP=1 and STEP=8) share one stimulus
// stream and are compared every cycle against a behavioural model, plus
// directed literal expectations on the key timing points.
module tb_duty_ramp;
  localparam int WIDTH    = 10;
  localparam int TICK_DIV = 4;
  localparam int DUTY_MAX = 1000;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_STOP  = 3;
  localparam int M_FAULT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic fault = 1'b0;
  logic [WIDTH-1:0] target = '0;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  int step_of[2] = '{1, 8};
  int m_mode[2];
  int m_d[2];
  int m_cnt[2];

  duty_ramp_if #(.WIDTH(WIDTH)) if0 ();
  duty_ramp_if #(.WIDTH(WIDTH)) if1 ();

  assign if0.en = en;
  assign if0.fault = fault;
  assign if0.target = target;
  assign if1.en = en;
  assign if1.fault = fault;
  assign if1.target = target;

  duty_ramp #(.WIDTH(WIDTH), .STEP(1), .TICK_DIV(TICK_DIV), .DUTY_MAX(DUTY_MAX))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  duty_ramp #(.WIDTH(WIDTH), .STEP(8), .TICK_DIV(TICK_DIV), .DUTY_MAX(DUTY_MAX))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int approach(input int cur, input int goal, input int step);
    if (cur < goal) return (goal - cur <= step) ? goal : cur + step;
    return (cur - goal <= step) ? goal : cur - step;
  endfunction

  // Behavioural model: mode, duty, and cycles elapsed since the last tick
  // or mode entry; a tick fires when TICK_DIV cycles have elapsed.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int g;
      g = (int'(target) > DUTY_MAX) ? DUTY_MAX : int'(target);
      if (rst) begin
        m_mode[k] = M_IDLE; m_d[k] = 0; m_cnt[k] = 0;
      end else if (fault) begin
        m_mode[k] = M_FAULT; m_d[k] = 0; m_cnt[k] = 0;
      end else begin
        case (m_mode[k])
          M_IDLE: if (en) begin
            m_mode[k] = (g != 0) ? M_RAMP : M_HOLD;
            m_cnt[k] = 0;
          end
          M_RAMP: begin
            if (!en) begin
              m_mode[k] = M_STOP;
              m_cnt[k] = (m_cnt[k] + 1) % TICK_DIV;
            end else if (m_d[k] == g) begin
              m_mode[k] = M_HOLD; m_cnt[k] = 0;
            end else begin
              m_cnt[k]++;
              if (m_cnt[k] == TICK_DIV) begin
                m_cnt[k] = 0;
                m_d[k] = approach(m_d[k], g, step_of[k]);
                if (m_d[k] == g) m_mode[k] = M_HOLD;
              end
            end
          end
          M_HOLD: begin
            if (!en) begin
              m_mode[k] = (m_d[k] == 0) ? M_IDLE : M_STOP; m_cnt[k] = 0;
            end else if (g != m_d[k]) begin
              m_mode[k] = M_RAMP; m_cnt[k] = 0;
            end
          end
          M_STOP: begin
            if (en) begin
              m_mode[k] = M_RAMP; m_cnt[k] = 0;
            end else if (m_d[k] == 0) begin
              m_mode[k] = M_IDLE; m_cnt[k] = 0;
            end else begin
              m_cnt[k]++;
              if (m_cnt[k] == TICK_DIV) begin
                m_cnt[k] = 0;
                m_d[k] = approach(m_d[k], 0, step_of[k]);
                if (m_d[k] == 0) m_mode[k] = M_IDLE;
              end
            end
          end
          default: if (!en) m_mode[k] = M_IDLE;
        endcase
      end
    end
  endtask

  initial begin
    m_mode = '{M_IDLE, M_IDLE};
    m_d = '{0, 0};
    m_cnt = '{0, 0};
    forever begin
      @(posedge clk);
      model_step();
      armed = 1'b1;
    end
  end

  task automatic cmp(input int k, input logic [WIDTH-1:0] d, input logic at,
                     input logic fl, input logic bz);
    string s;
    s = (k == 0) ? "s1" : "s8";
    check({s, "_d"}, 32'(d), 32'(m_d[k]));
    check({s, "_at_target"}, 32'(at), 32'(m_mode[k] == M_HOLD));
    check({s, "_fault_latched"}, 32'(fl), 32'(m_mode[k] == M_FAULT));
    check({s, "_busy"}, 32'(bz), 32'(m_mode[k] == M_RAMP || m_mode[k] == M_STOP));
  endtask

  // scoreboard compare on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        cmp(0, if0.d, if0.at_target, if0.fault_latched, if0.busy);
        cmp(1, if1.d, if1.at_target, if1.fault_latched, if1.busy);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_at_target(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if0.at_target) break;
    end
    check(name, 32'(if0.at_target), 32'd1);
  endtask

  task automatic wait_d(input string name, input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(if0.d) == val) break;
    end
    check(name, 32'(if0.d), 32'(val));
  endtask

  initial begin
    // reset with run already requested
    rst = 1'b1; en = 1'b1; target = 10'd500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_d", 32'(if0.d), 32'd0);
      check("rst_flags", {29'd0, if0.at_target, if0.fault_latched, if0.busy}, 32'd0);
    end
    rst = 1'b0;
    cycles(4);
    check("first_step_not_yet", 32'(if0.d), 32'd0);
    cycles(1);
    check("first_step_d1", 32'(if0.d), 32'd1);
    check("first_step_s8", 32'(if1.d), 32'd8);
    wait_at_target("reach_500", 2100);
    check("hold_500", 32'(if0.d), 32'd500);

    // step down by three
    target = 10'd497;
    cycles(12);
    check("down_498", 32'(if0.d), 32'd498);
    cycles(1);
    check("down_497", 32'(if0.d), 32'd497);
    check("down_hold", 32'(if0.at_target), 32'd1);

    // small rise: STEP=8 lands in one step with no overshoot
    target = 10'd503;
    cycles(5);
    check("s8_one_step", 32'(if1.d), 32'd503);
    check("s1_first_up", 32'(if0.d), 32'd498);
    wait_at_target("reach_503", 40);

    // saturation
    target = 10'd1023;
    wait_at_target("reach_max", 2100);
    check("sat_d", 32'(if0.d), 32'd1000);
    check("sat_busy", 32'(if0.busy), 32'd0);
    check("sat_s8", 32'(if1.d), 32'd1000);

    // fault mid-ramp
    target = 10'd200;
    wait_d("reach_300", 300, 3000);
    fault = 1'b1;
    cycles(1);
    check("fault_d0", 32'(if0.d), 32'd0);
    check("fault_latched", 32'(if0.fault_latched), 32'd1);
    fault = 1'b0;
    cycles(3);
    check("fault_stays_en1", 32'(if0.fault_latched), 32'd1);
    en = 1'b0;
    cycles(1);
    check("fault_cleared", 32'(if0.fault_latched), 32'd0);
    check("fault_idle_busy", 32'(if0.busy), 32'd0);
    en = 1'b1; target = 10'd6;
    cycles(1);
    check("restart_busy", 32'(if0.busy), 32'd1);
    check("restart_d0", 32'(if0.d), 32'd0);

    // soft stop from 6
    wait_at_target("reach_6", 40);
    en = 1'b0;
    cycles(24);
    check("stop_d1", 32'(if0.d), 32'd1);
    check("stop_busy", 32'(if0.busy), 32'd1);
    cycles(1);
    check("stop_d0", 32'(if0.d), 32'd0);
    check("stop_idle", 32'(if0.busy), 32'd0);

    // re-enable during stop at d=3
    en = 1'b1;
    wait_at_target("reach_6b", 40);
    en = 1'b0;
    wait_d("stop_to_3", 3, 40);
    en = 1'b1;
    cycles(4);
    check("resume_hold3", 32'(if0.d), 32'd3);
    check("resume_busy", 32'(if0.busy), 32'd1);
    cycles(1);
    check("resume_up4", 32'(if0.d), 32'd4);

    // reset together with fault, at every prescaler phase
    for (int i = 0; i < 4; i++) begin
      rst = 1'b1; en = 1'b0;
      cycles(2);
      rst = 1'b0; en = 1'b1; target = 10'd50;
      cycles(5 + i);
      rst = 1'b1; fault = 1'b1;
      cycles(1);
      check("rstfault_d", 32'(if0.d), 32'd0);
      check("rstfault_flags", {29'd0, if0.at_target, if0.fault_latched, if0.busy}, 32'd0);
      rst = 1'b0; fault = 1'b0; en = 1'b0;
      cycles(1);
    end

    // randomized traffic checked by the model
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) target = WIDTH'($urandom_range(0, 1023));
      else if (r < 10) target = WIDTH'($urandom_range(0, 24));
      else if (r < 13) en = ~en;
      fault = (r == 199);
      rst = (r == 198);
      @(negedge clk);
    end
    rst = 1'b0; fault = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/duty_ramp.md
Name: duty_ramp

Overview:
- Upstream setpoint stage for the half-bridge PWM/dead-time path.
- Takes a requested duty command and produces the 10-bit duty word `d` that feeds the PWM.
- Limits slew on start, stop and setpoint changes so the bridge never sees a duty step larger than STEP per tick.
- On fault, forces duty to zero immediately and latches until cleared.

Parameters:
- WIDTH, 10, duty word width (matches the PWM `d` input)
- STEP, 1, duty increment/decrement applied per ramp tick
- TICK_DIV, 50000, clk cycles per ramp tick (500 us at 100 MHz clk)
- DUTY_MAX, 1000, saturation ceiling applied to the target

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  synchronous active-high reset
- en  input  1  run request; 1 = ramp to target, 0 = soft stop to zero
- fault  input  1  level fault from protection; forces immediate shutdown
- target  input  WIDTH  requested duty, sampled every cycle
- d  output  WIDTH  registered duty command to the PWM stage
- at_target  output  1  high while in HOLD (d equals clamped target)
- fault_latched  output  1  high while in FAULT
- busy  output  1  high in RAMP or STOP

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - d = 0, state = IDLE
  - at_target = 0, fault_latched = 0, busy = 0
  - prescaler = 0
- All outputs are registered.
- Priority, highest first: rst, fault, FSM logic.
- tgt = min(target, DUTY_MAX), evaluated combinationally each cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RAMP or STOP.
  - tick = 1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Held at 0 in IDLE, HOLD and FAULT.
  - Cleared on every state entry, so the first step lands exactly TICK_DIV cycles after entry.
- Step arithmetic, performed in WIDTH+1 bits with no wrap:
  - Up: d <= (tgt - d <= STEP) ? tgt : d + STEP.
  - Down: d <= (d - tgt <= STEP) ? tgt : d - STEP.
  - The STOP target is 0.
- States and transitions:
  - IDLE: d = 0. en=1 and tgt != 0 -> RAMP. en=1 and tgt == 0 -> HOLD.
  - RAMP:
    - On tick, step d toward tgt.
    - Next state is HOLD when the new d equals tgt, or when d == tgt at any cycle.
    - en=0 -> STOP. The prescaler is not cleared on this transition, so the tick cadence continues.
  - HOLD: d held. tgt != d -> RAMP (prescaler cleared). en=0 -> STOP, or IDLE if d == 0.
  - STOP:
    - On tick, step d toward 0; next state is IDLE when d reaches 0.
    - en=1 again -> RAMP with the current d, no reset of d.
  - FAULT:
    - d = 0 in the same clock edge that samples fault=1, from any state.
    - Exit to IDLE only when fault=0 and en=0 in the same cycle. en=1 with fault=0 keeps FAULT (re-arm requires en low).
- Target changes mid-ramp: the direction is re-evaluated every tick. Overshoot is impossible by the clamp rule.
- A target above DUTY_MAX saturates at DUTY_MAX. at_target asserts when d == DUTY_MAX.
- rst asserted mid-ramp: next edge gives d = 0, IDLE. No partial step is retained.
- Latency: a change of d is visible one cycle after the tick cycle. The fault-to-d=0 latency is 1 clk.

Test Plan (TICK_DIV=4, STEP=1, DUTY_MAX=1000 unless noted):
- rst high 3 cycles, en=1, target=500 -> d=0, all flags 0 during reset. After release, d=1 first appears 5 cycles after rst falls (enters RAMP, 4-cycle tick, +1 register). d increments once every 4 cycles; at_target=1 when d=500.
- HOLD at d=500, target changed to 497 -> d goes 499, 498, 497 at 4-cycle spacing, then HOLD. STEP=8 variant, d=500 -> target 503: d=503 in one step, no overshoot.
- target=1023 -> d saturates at 1000, at_target=1. busy=0 thereafter.
- d=300 ramping, fault pulsed 1 cycle -> d=0 next edge, fault_latched=1. With en still 1 it stays FAULT; en=0 for one cycle -> IDLE. en=1 -> ramp restarts from 0.
- HOLD d=6, en=0 -> STOP, d reaches 0 in 6 ticks (24 cycles), then IDLE. en reasserted at d=3 -> RAMP upward from 3.
- rst asserted in the same cycle as fault and a tick -> d=0, IDLE, fault_latched=0 (reset wins).
